// File: rtl/bcd_countdown_timer_pkg.sv
// Shared definitions for the BCD countdown timer: FSM state encoding,
// the largest legal BCD digit and the load-value clamp helper.
package bcd_countdown_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_RUN    = 2'd1,
        ST_PAUSED = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam logic [3:0] BCD_MAX = 4'd9;

    // Any nibble above 9 is not a BCD digit; saturate it to 9.
    function automatic logic [3:0] bcd_clamp(input logic [3:0] nib);
        return (nib > BCD_MAX) ? BCD_MAX : nib;
    endfunction

endpackage

// File: rtl/bcd_down_digit.sv
// One BCD digit of the down-counter. A load overrides everything; otherwise
// the digit steps down by one whenever a borrow arrives, wrapping 0 -> 9 and
// passing the borrow on to the next digit.
module bcd_down_digit
    import bcd_countdown_timer_pkg::*;
(
    input  logic       mclk,
    input  logic       rst_n,
    input  logic       ld,
    input  logic [3:0] ld_val,
    input  logic       borrow_in,
    output logic [3:0] digit,
    output logic       borrow_out
);

    logic [3:0] digit_q;
    logic [3:0] digit_d;

    // Next digit value: load wins, then a borrow decrements with 0 -> 9 wrap.
    always_comb begin
        digit_d = digit_q;
        if (ld) begin
            digit_d = ld_val;
        end else if (borrow_in) begin
            digit_d = (digit_q == 4'd0) ? BCD_MAX : (digit_q - 4'd1);
        end
    end

    // Digit register, cleared asynchronously.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            digit_q <= 4'd0;
        end else begin
            digit_q <= digit_d;
        end
    end

    assign digit      = digit_q;
    assign borrow_out = borrow_in & (digit_q == 4'd0);

endmodule

// File: rtl/bcd_countdown_timer.sv
// Multi-digit BCD countdown timer. A prescaler turns mclk into decrement
// ticks while the FSM is in RUN; the digit chain does the BCD arithmetic.
// Control priority each cycle is load > start > pause. Reaching zero by a
// tick parks the FSM in DONE and raises a one-cycle done pulse.
// Handshake/control semantics: load/start/pause are plain levels sampled on
// every rising mclk edge; there is no valid/ready pairing on this block.
module bcd_countdown_timer
    import bcd_countdown_timer_pkg::*;
#(
    parameter int DIGITS   = 4,
    parameter int TICK_DIV = 50000
) (
    input  logic                mclk,
    input  logic                rst_n,
    input  logic                load,
    input  logic [4*DIGITS-1:0] load_val,
    input  logic                start,
    input  logic                pause,
    output logic [4*DIGITS-1:0] count,
    output logic                running,
    output logic                zero,
    output logic                done,
    output logic [1:0]          state_o
);

    localparam int CW = 4 * DIGITS;
    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] COUNT_ONE  = CW'(1);

    state_e        state_q, state_d;
    logic [PW-1:0] presc_q, presc_d;
    logic          done_q, done_d;
    logic          tick;
    logic [CW-1:0] load_clamped;
    logic [DIGITS:0] borrow;

    // Saturate each loaded nibble to a legal BCD digit.
    always_comb begin
        load_clamped = '0;
        for (int i = 0; i < DIGITS; i++) begin
            load_clamped[4*i +: 4] = bcd_clamp(load_val[4*i +: 4]);
        end
    end

    // A tick fires on the last prescaler cycle of an uninterrupted RUN cycle;
    // load or pause in that cycle suppresses it.
    assign tick = !load && (state_q == ST_RUN) && !pause && (presc_q == PRESC_LAST);

    assign borrow[0] = tick;

    genvar g;
    generate
        for (g = 0; g < DIGITS; g++) begin : g_digit
            bcd_down_digit u_digit (
                .mclk       (mclk),
                .rst_n      (rst_n),
                .ld         (load),
                .ld_val     (load_clamped[4*g +: 4]),
                .borrow_in  (borrow[g]),
                .digit      (count[4*g +: 4]),
                .borrow_out (borrow[g+1])
            );
        end
    endgenerate

    // Next-state, prescaler and done-pulse logic.
    always_comb begin
        state_d = state_q;
        presc_d = presc_q;
        done_d  = 1'b0;
        if (load) begin
            state_d = ST_IDLE;
            presc_d = '0;
        end else begin
            case (state_q)
                ST_IDLE: begin
                    // Starting from zero would finish instantly; ignore it.
                    if (start && !zero) begin
                        state_d = ST_RUN;
                        presc_d = '0;
                    end
                end
                ST_RUN: begin
                    if (pause) begin
                        state_d = ST_PAUSED;
                    end else if (presc_q == PRESC_LAST) begin
                        presc_d = '0;
                    end else begin
                        presc_d = presc_q + PW'(1);
                    end
                end
                ST_PAUSED: begin
                    if (start) begin
                        state_d = ST_RUN;
                    end
                end
                ST_DONE: begin
                    state_d = ST_DONE;
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
            // A tick from 0..01 lands on zero. A borrow out of the top digit
            // cannot occur from RUN, but if it ever did, stop rather than
            // keep counting down from 99..9.
            if (tick && ((count == COUNT_ONE) || borrow[DIGITS])) begin
                state_d = ST_DONE;
                done_d  = 1'b1;
            end
        end
    end

    // FSM, prescaler and done registers, cleared asynchronously.
    always_ff @(posedge mclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            presc_q <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            presc_q <= presc_d;
            done_q  <= done_d;
        end
    end

    assign running = (state_q == ST_RUN);
    assign zero    = ~|count;
    assign done    = done_q;
    assign state_o = state_q;

endmodule
